// File: rtl/boot_copy_sequencer_if.sv
// rtl/boot_copy_sequencer_if.sv - boot copy sequencer bus bundle (ROM, core download, HPS download)
// The master modport is the sequencer side; slave is the ROM/core/HPS side.
interface boot_copy_sequencer_if;
  logic        dn_wait;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        host_download;
  logic        host_wr;
  logic [15:0] host_addr;
  logic [7:0]  host_data;
  logic        dn_go;
  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic [15:0] execute_addr;
  logic        execute_enable;
  logic        busy;

  modport master (
    input  dn_wait, rom_data, host_download, host_wr, host_addr, host_data,
    output rom_addr, dn_go, dn_wr, dn_addr, dn_data, execute_addr, execute_enable, busy
  );

  modport slave (
    output dn_wait, rom_data, host_download, host_wr, host_addr, host_data,
    input  rom_addr, dn_go, dn_wr, dn_addr, dn_data, execute_addr, execute_enable, busy
  );
endinterface

// File: rtl/boot_copy_sequencer.sv
// rtl/boot_copy_sequencer.sv - copies boot ROM bytes 0..BOOT_ROM_END into the core, then starts it
// An active HPS download takes over the core write port and restarts the copy when it ends.
module boot_copy_sequencer #(
  parameter logic [15:0] BOOT_ROM_END = 16'd275,
  parameter logic [15:0] EXEC_ADDR    = 16'h0000
) (
  input logic                   clk_sys,
  input logic                   reset_n,
  boot_copy_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, WRITE, EXEC, DONE, HOST} state_t;

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] dn_addr_q, dn_addr_d;
  logic [7:0]  dn_data_q, dn_data_d;

  logic        go;
  logic        wr;
  logic        exe;
  logic [15:0] addr_o;
  logic [7:0]  data_o;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      n_q       <= 16'd0;
      dn_addr_q <= 16'd0;
      dn_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      dn_addr_q <= dn_addr_d;
      dn_data_q <= dn_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    dn_addr_d = dn_addr_q;
    dn_data_d = dn_data_q;
    go        = 1'b0;
    wr        = 1'b0;
    exe       = 1'b0;
    addr_o    = dn_addr_q;
    data_o    = dn_data_q;

    case (state_q)
      IDLE: begin
        n_d     = 16'd0;
        state_d = FETCH;
      end
      FETCH: begin
        go      = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        go        = 1'b1;
        dn_addr_d = n_q;
        dn_data_d = bus.rom_data;
        state_d   = WRITE;
      end
      WRITE: begin
        go = 1'b1;
        if (!bus.dn_wait) begin
          wr = 1'b1;
          // >= rather than == keeps n from ever running past the last byte
          if (n_q >= BOOT_ROM_END) begin
            state_d = EXEC;
          end else begin
            n_d     = n_q + 16'd1;
            state_d = FETCH;
          end
        end
      end
      EXEC: begin
        exe     = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = DONE;
      end
      HOST: begin
        go      = 1'b1;
        wr      = bus.host_wr;
        addr_o  = bus.host_addr;
        data_o  = bus.host_data;
        state_d = bus.host_download ? HOST : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A strobe already on the bus this cycle still completes; only the next state changes.
    if (bus.host_download && state_q != HOST) begin
      state_d = HOST;
    end
  end

  assign bus.rom_addr       = n_q;
  assign bus.dn_go          = go;
  assign bus.dn_wr          = wr;
  assign bus.dn_addr        = addr_o;
  assign bus.dn_data        = data_o;
  assign bus.execute_addr   = EXEC_ADDR;
  assign bus.execute_enable = exe;
  assign bus.busy           = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_boot_copy_sequencer.sv
// tb/tb_boot_copy_sequencer.sv - self-checking bench for boot_copy_sequencer
`timescale 1ns/1ps
module tb_boot_copy_sequencer;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    string      name;
    int         kind;
    int         at_n;
    logic [7:0] key;
    int         exp_wr;
    int         exp_exec;
    int         exp_cycle;
  } vec_t;

  logic clk_sys = 1'b0;
  logic reset_n;
  logic reset0_n;
  logic [7:0] rom_key;

  boot_copy_sequencer_if bus();
  boot_copy_sequencer_if bus0();

  boot_copy_sequencer dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  boot_copy_sequencer #(.BOOT_ROM_END(16'd0)) dut0 (
    .clk_sys (clk_sys),
    .reset_n (reset0_n),
    .bus     (bus0)
  );

  always #15.625 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    bus.rom_data  <= bus.rom_addr[7:0] ^ rom_key;
    bus0.rom_data <= bus0.rom_addr[7:0] ^ 8'h3C;
  end

  int n_checks = 0;
  int n_pass   = 0;
  wr_t exp_q[$];
  int wr_count   = 0;
  int exec_count = 0;
  int exec_cycle = -1;
  int fetch_cnt  = 0;
  logic busy_prev = 1'b0;

  logic        nxt_reset_n, nxt_reset0_n, nxt_wait, nxt_hd, nxt_hw;
  logic [15:0] nxt_ha;
  logic [7:0]  nxt_hdat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic monitor();
    wr_t e;
    if (bus.dn_wr) begin
      wr_count++;
      chk("sb_pending", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.dn_addr, e.addr);
        chk("wr_data", bus.dn_data, e.data);
        chk("wr_go", bus.dn_go, 1);
      end
    end
    if (bus.busy && !busy_prev) fetch_cnt = 0;
    else if (bus.busy) fetch_cnt++;
    busy_prev = bus.busy;
    if (bus.execute_enable) begin
      exec_count++;
      exec_cycle = fetch_cnt;
      chk("exec_go_low", bus.dn_go, 0);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
    reset_n            = nxt_reset_n;
    reset0_n           = nxt_reset0_n;
    bus.dn_wait        = nxt_wait;
    bus.host_download  = nxt_hd;
    bus.host_wr        = nxt_hw;
    bus.host_addr      = nxt_ha;
    bus.host_data      = nxt_hdat;
    @(negedge clk_sys);
    monitor();
  endtask

  task automatic push_range(input int last, input logic [7:0] key);
    wr_t w;
    for (int k = 0; k <= last; k++) begin
      w.addr = 16'(k);
      w.data = 8'(k) ^ key;
      exp_q.push_back(w);
    end
  endtask

  function automatic logic [63:0] outs_main();
    return {bus.dn_go, bus.dn_wr, bus.dn_addr, bus.dn_data, bus.rom_addr, bus.execute_enable, bus.busy};
  endfunction

  task automatic do_reset();
    nxt_reset_n = 1'b0;
    step();
    step();
    chk("reset_outputs", outs_main(), 0);
    nxt_reset_n = 1'b1;
    step();
    chk("release_idle", {bus.busy, bus.dn_go}, 0);
    step();
    chk("first_fetch", {bus.busy, bus.dn_go, bus.dn_wr, bus.rom_addr}, {3'b110, 16'h0000});
  endtask

  initial begin
    vec_t vecs[4];
    int   wr0, ex0, cnt;
    bit   fired;
    wr_t  w;

    vecs[0] = '{name:"plain", kind:0, at_n:0,   key:8'h00, exp_wr:276, exp_exec:1, exp_cycle:828};
    vecs[1] = '{name:"wait",  kind:1, at_n:10,  key:8'h5A, exp_wr:276, exp_exec:1, exp_cycle:832};
    vecs[2] = '{name:"reset", kind:2, at_n:100, key:8'hA5, exp_wr:376, exp_exec:1, exp_cycle:828};
    vecs[3] = '{name:"host",  kind:3, at_n:50,  key:8'h3C, exp_wr:329, exp_exec:1, exp_cycle:828};

    rom_key      = 8'h00;
    nxt_reset_n  = 1'b0;
    nxt_reset0_n = 1'b0;
    nxt_wait     = 1'b0;
    nxt_hd       = 1'b0;
    nxt_hw       = 1'b0;
    nxt_ha       = 16'h0;
    nxt_hdat     = 8'h0;
    reset_n      = 1'b0;
    reset0_n     = 1'b0;
    bus.dn_wait  = 1'b0;
    bus.host_download = 1'b0;
    bus.host_wr  = 1'b0;
    bus.host_addr = 16'h0;
    bus.host_data = 8'h0;
    bus0.dn_wait = 1'b0;
    bus0.host_download = 1'b0;
    bus0.host_wr = 1'b0;
    bus0.host_addr = 16'h0;
    bus0.host_data = 8'h0;

    // Single-byte ROM instance, main instance held in reset meanwhile.
    step();
    step();
    chk("rst_main_outputs", outs_main(), 0);
    chk("rst0_outputs", {bus0.dn_go, bus0.dn_wr, bus0.dn_addr, bus0.dn_data, bus0.rom_addr, bus0.execute_enable, bus0.busy}, 0);
    chk("exec_addr_main", bus.execute_addr, 16'h0000);
    nxt_reset0_n = 1'b1;
    step();
    chk("end0_idle", bus0.busy, 0);
    step();
    chk("end0_fetch", {bus0.dn_go, bus0.busy, bus0.rom_addr}, {2'b11, 16'h0000});
    step();
    chk("end0_capture_nowr", bus0.dn_wr, 0);
    step();
    chk("end0_write", {bus0.dn_wr, bus0.dn_go, bus0.dn_addr, bus0.dn_data}, {2'b11, 16'h0000, 8'h3C});
    step();
    chk("end0_exec", {bus0.execute_enable, bus0.dn_go, bus0.dn_wr, bus0.busy}, 4'b1001);
    chk("end0_exec_addr", bus0.execute_addr, 16'h0000);
    step();
    chk("end0_done", {bus0.execute_enable, bus0.dn_go, bus0.dn_wr, bus0.busy}, 4'b0000);
    repeat (4) step();
    chk("end0_done_held", {bus0.execute_enable, bus0.dn_go, bus0.dn_wr, bus0.busy}, 4'b0000);

    for (int i = 0; i < 4; i++) begin
      rom_key = vecs[i].key;
      exp_q.delete();
      if (vecs[i].kind == 2) push_range(vecs[i].at_n - 1, vecs[i].key);
      if (vecs[i].kind == 3) begin
        push_range(vecs[i].at_n - 1, vecs[i].key);
        for (int j = 0; j < 3; j++) begin
          w.addr = 16'h4000 + 16'(j);
          w.data = 8'hC0 + 8'(j);
          exp_q.push_back(w);
        end
      end
      push_range(275, vecs[i].key);
      wr0 = wr_count;
      ex0 = exec_count;
      do_reset();
      fired = 1'b0;
      cnt   = 0;
      while (exec_count == ex0 && cnt < 3000) begin
        if (vecs[i].kind != 0 && !fired && bus.busy && bus.rom_addr == 16'(vecs[i].at_n)) begin
          fired = 1'b1;
          case (vecs[i].kind)
            1: begin
              nxt_wait = 1'b1;
              for (int j = 0; j < 5; j++) begin
                step();
                chk("wait_nowr", bus.dn_wr, 0);
                if (j >= 1) begin
                  chk("wait_addr", bus.dn_addr, 16'(vecs[i].at_n));
                  chk("wait_data", bus.dn_data, 8'(vecs[i].at_n) ^ vecs[i].key);
                end
              end
              nxt_wait = 1'b0;
            end
            2: begin
              nxt_reset_n = 1'b0;
              step();
              step();
              chk("midcopy_reset_outputs", outs_main(), 0);
              nxt_reset_n = 1'b1;
              step();
              chk("midcopy_reset_held", outs_main(), 0);
            end
            default: begin
              nxt_hd = 1'b1;
              step();
              chk("host_entry_nowr", bus.dn_wr, 0);
              for (int j = 0; j < 3; j++) begin
                nxt_hw   = 1'b1;
                nxt_ha   = 16'h4000 + 16'(j);
                nxt_hdat = 8'hC0 + 8'(j);
                nxt_wait = (j == 1);
                step();
                chk("host_go", {bus.dn_go, bus.busy, bus.execute_enable, bus.dn_wr}, 4'b1101);
                nxt_hw = 1'b0;
                step();
                chk("host_idle_nowr", {bus.dn_go, bus.dn_wr}, 2'b10);
              end
              nxt_hd   = 1'b0;
              nxt_wait = 1'b0;
            end
          endcase
        end
        step();
        cnt++;
      end
      chk($sformatf("%s_no_timeout", vecs[i].name), (cnt < 3000), 1);
      repeat (6) step();
      chk($sformatf("%s_done_idle", vecs[i].name), {bus.busy, bus.dn_go, bus.dn_wr, bus.execute_enable}, 0);
      chk($sformatf("%s_wr_count", vecs[i].name), wr_count - wr0, vecs[i].exp_wr);
      chk($sformatf("%s_exec_count", vecs[i].name), exec_count - ex0, vecs[i].exp_exec);
      chk($sformatf("%s_exec_cycle", vecs[i].name), exec_cycle, vecs[i].exp_cycle);
      chk($sformatf("%s_sb_drained", vecs[i].name), exp_q.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/boot_copy_sequencer.md
BOOT_COPY_SEQUENCER -- requirements
Module: boot_copy_sequencer

Interface
REQ-001 Parameter BOOT_ROM_END, default 16'd275, last boot ROM address copied (inclusive).
REQ-002 Parameter EXEC_ADDR, default 16'h0000, value driven on execute_addr.
REQ-003 clk_sys  in  1  system clock (32 MHz); all logic on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 dn_wait  in  1  core back-pressure; when high, no dn_wr from the sequencer.
REQ-006 rom_addr  out  16  boot ROM read address.
REQ-007 rom_data  in  8  boot ROM data, valid one clk_sys after rom_addr (registered ROM).
REQ-008 host_download  in  1  HPS ROM download active (ioctl_download with index 0).
REQ-009 host_wr, host_addr[15:0], host_data[7:0]  in  HPS write strobe, address, data.
REQ-010 dn_go  out  1  download-in-progress flag to the core.
REQ-011 dn_wr  out  1  one-cycle write strobe to the core.
REQ-012 dn_addr  out  16 / dn_data  out  8  write address and data to the core.
REQ-013 execute_addr  out  16  start address for the core; constant EXEC_ADDR.
REQ-014 execute_enable  out  1  one-cycle pulse after a completed copy.
REQ-015 busy  out  1  high in any state other than IDLE/DONE.

Function
REQ-016 States: IDLE, FETCH, CAPTURE, WRITE, EXEC, DONE, HOST.
REQ-017 IDLE: always exits to FETCH on the next cycle, with byte index n=0.
REQ-018 FETCH: rom_addr=n; always exits to CAPTURE.
REQ-019 CAPTURE: dn_data<=rom_data and dn_addr<=n are registered; always exits to WRITE.
REQ-020 WRITE with dn_wait=0: dn_wr=1 for exactly this cycle.
REQ-021 WRITE with dn_wait=1: dn_wr=0 and the state holds; dn_addr and dn_data stay stable.
REQ-022 After a strobed WRITE with n<BOOT_ROM_END: n<=n+1, next state FETCH.
REQ-023 After a strobed WRITE with n==BOOT_ROM_END: next state EXEC.
REQ-024 n is 16 bits; it never wraps because the compare stops at BOOT_ROM_END.
REQ-025 EXEC: execute_enable=1 for one cycle and dn_go=0 in the same cycle; next state DONE.
REQ-026 dn_go=1 in FETCH, CAPTURE and WRITE, and 0 otherwise, except in HOST.
REQ-027 Total bytes copied = BOOT_ROM_END+1; with dn_wait=0 throughout, a copy takes 3*(BOOT_ROM_END+1) cycles from the first FETCH.
REQ-028 HOST entry: host_download=1 in any state goes to HOST on the next cycle; an in-flight copy is abandoned and no further sequencer dn_wr is issued.
REQ-029 HOST outputs: dn_go=1, dn_wr=host_wr, dn_addr=host_addr and dn_data=host_data (combinational pass-through); dn_wait is ignored; execute_enable=0.
REQ-030 HOST exit: on host_download falling, go to IDLE; the copy restarts from n=0.
REQ-031 host_download rising on the same cycle a strobed WRITE occurs: that strobe completes, then HOST is entered.
REQ-032 DONE: outputs idle (dn_go=0, dn_wr=0); held until reset or host_download.

Reset
REQ-033 reset_n=0 sampled on a clock edge: state IDLE and n=0.
REQ-034 While reset_n=0, the next edge drives dn_go=0, dn_wr=0, dn_addr=0, dn_data=0, rom_addr=0, execute_enable=0 and busy=0.
REQ-035 While reset_n=0, no writes are issued.
REQ-036 Reset asserted mid-copy aborts the copy immediately; the copy restarts from n=0 after release.
REQ-037 The first FETCH occurs on the second edge after reset_n is sampled high.

Verification
REQ-038 Release reset, dn_wait=0, ROM[k]=k[7:0] -> 276 dn_wr pulses with dn_addr 0..275 and dn_data = addr[7:0]; execute_enable pulses once, 828 cycles after the first FETCH; then DONE.
REQ-039 dn_wait=1 held 5 cycles while at n=10 -> dn_addr=10 and dn_data stable, no dn_wr; exactly one write of 10 after release; total dn_wr count still 276.
REQ-040 reset_n=0 at n=100 for 2 cycles -> all outputs 0; after release the copy restarts at dn_addr=0; exactly one execute_enable at the end.
REQ-041 host_download=1 at n=50, 3 host writes to 0x4000..0x4002 -> dn_wr mirrors host_wr with host address/data, dn_go=1; after host_download=0 the copy reruns 0..275 and then execute_enable pulses.
REQ-042 BOOT_ROM_END=0 -> a single dn_wr to address 0, then execute_enable 1 cycle later; dn_go=0 in the EXEC cycle.
